// File: rtl/mips_pkg.sv
// Shared definitions for the 16-bit pipelined MIPS datapath.
// Provides:
//   REG_AW    - register index width
//   NREGS     - number of architectural registers (r0 hardwired zero)
//   reg_idx_t - register index type
//   REG_ZERO  - index of the hardwired-zero register
//   cnt_op_t  - per-register pending-counter operation
package mips_pkg;
  localparam int unsigned REG_AW = 3;
  localparam int unsigned NREGS  = 8;

  typedef logic [REG_AW-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC
  } cnt_op_t;
endpackage

// File: rtl/reg_scoreboard_counter.sv
// sb_counter: pending-write counter for one architectural register.
// Saturates at both ends. A simultaneous inc and dec leaves the count unchanged.
// Ports:
//   clk     - clock; state updates on posedge
//   clr_i   - synchronous clear (driven by the scoreboard reset)
//   inc_i   - an instruction writing this register issues
//   dec_i   - writeback commits this register
//   busy_o  - count is nonzero
//   count_o - current pending count
module sb_counter
  import mips_pkg::*;
#(
  parameter int unsigned CW = 2
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic          busy_o,
  output logic [CW-1:0] count_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  cnt_op_t       op;

  always_comb begin
    op = CNT_HOLD;
    if (inc_i && !dec_i && cnt_q != '1) begin
      op = CNT_INC;
    end else if (dec_i && !inc_i && cnt_q != '0) begin
      op = CNT_DEC;
    end

    cnt_d = cnt_q;
    case (op)
      CNT_INC: cnt_d = cnt_q + 1'b1;
      CNT_DEC: cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o  = (cnt_q != '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: decode-stage read-hazard guard.
// Tracks in-flight writes per architectural register and stalls issue while a
// source operand is still awaiting writeback, or while the destination's
// pending counter is full.
// Optional feature macro: SB_WB_BYPASS_EN -- when defined, a source whose last
// pending write commits this cycle is treated as ready (negedge regfile write).
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   issue_valid                  - decode holds an instruction
//   issue_regwrite/writereg      - issuing instruction's destination
//   readreg1/2, uses_rs1/2       - source indices and use flags
//   wb_regwrite/wb_writereg      - writeback commit
//   stall, issue_fire            - combinational issue control
//   busy_vec                     - registered per-register pending flags
//   err                          - sticky: retire with no pending write
module reg_scoreboard #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned CW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic             issue_regwrite,
  input  logic [AW-1:0]    issue_writereg,
  input  logic [AW-1:0]    readreg1,
  input  logic [AW-1:0]    readreg2,
  input  logic             uses_rs1,
  input  logic             uses_rs2,
  input  logic             wb_regwrite,
  input  logic [AW-1:0]    wb_writereg,
  output logic             stall,
  output logic             issue_fire,
  output logic [NREGS-1:0] busy_vec,
  output logic             err
);
  import mips_pkg::*;

  localparam logic [AW-1:0] RZ      = AW'(REG_ZERO);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0]    cnt [NREGS];
  logic [NREGS-1:0] inc, dec, busy_now, busy_reg;
  logic             full;
  logic             err_q, err_d;

  // r0 has no counter; it reads as permanently idle.
  assign cnt[0]      = '0;
  assign busy_reg[0] = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    sb_counter #(.CW(CW)) u_cnt (
      .clk     (clk),
      .clr_i   (rst),
      .inc_i   (inc[r]),
      .dec_i   (dec[r]),
      .busy_o  (busy_reg[r]),
      .count_o (cnt[r])
    );
  end

  always_comb begin
    busy_now = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      busy_now[r] = (cnt[r] != '0);
`ifdef SB_WB_BYPASS_EN
      // Final pending write commits this cycle; regfile writes on negedge.
      if (cnt[r] == CW'(1) && wb_regwrite && wb_writereg == AW'(r)) begin
        busy_now[r] = 1'b0;
      end
`endif
    end

    // Full destination may still issue if the same register retires now.
    full = issue_regwrite && (issue_writereg != RZ) &&
           (cnt[issue_writereg] == CNT_MAX) &&
           !(wb_regwrite && wb_writereg == issue_writereg);

    stall = issue_valid &&
            ((uses_rs1 && busy_now[readreg1]) ||
             (uses_rs2 && busy_now[readreg2]) ||
             full);
    issue_fire = issue_valid && !stall;

    inc = '0;
    dec = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      inc[r] = issue_fire && issue_regwrite && (issue_writereg == AW'(r));
      dec[r] = wb_regwrite && (wb_writereg == AW'(r)) && (cnt[r] != '0);
    end

    err_d = err_q || (wb_regwrite && (wb_writereg != RZ) &&
                      (cnt[wb_writereg] == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign busy_vec = busy_reg;
  assign err      = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst, issue_valid, issue_regwrite, uses_rs1, uses_rs2, wb_regwrite;
  logic [2:0] issue_writereg, readreg1, readreg2, wb_writereg;
  logic       stall, issue_fire, err;
  logic [7:0] busy_vec;

  always #5 clk = ~clk;

  reg_scoreboard #(.NREGS(8), .AW(3), .CW(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_regwrite (issue_regwrite),
    .issue_writereg (issue_writereg),
    .readreg1       (readreg1),
    .readreg2       (readreg2),
    .uses_rs1       (uses_rs1),
    .uses_rs2       (uses_rs2),
    .wb_regwrite    (wb_regwrite),
    .wb_writereg    (wb_writereg),
    .stall          (stall),
    .issue_fire     (issue_fire),
    .busy_vec       (busy_vec),
    .err            (err)
  );

  typedef struct {
    bit       rst, iv, irw;
    bit [2:0] iwr, rr1, rr2;
    bit       u1, u2, wb;
    bit [2:0] wbr;
    bit       st, fi;
    bit [7:0] bv;
    bit       er;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model: pending write counts per register plus sticky error.
  int cnt_m [8];
  bit err_m;

  function automatic vec_t mk(int rs, int iv, int irw, int iwr, int rr1, int rr2,
                              int u1, int u2, int wb, int wbr,
                              int st, int fi, int bv, int er);
    vec_t m;
    m.rst = rs[0];  m.iv = iv[0];   m.irw = irw[0]; m.iwr = iwr[2:0];
    m.rr1 = rr1[2:0]; m.rr2 = rr2[2:0]; m.u1 = u1[0]; m.u2 = u2[0];
    m.wb = wb[0];   m.wbr = wbr[2:0];
    m.st = st[0];   m.fi = fi[0];   m.bv = bv[7:0]; m.er = er[0];
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    rst = v.rst; issue_valid = v.iv; issue_regwrite = v.irw; issue_writereg = v.iwr;
    readreg1 = v.rr1; readreg2 = v.rr2; uses_rs1 = v.u1; uses_rs2 = v.u2;
    wb_regwrite = v.wb; wb_writereg = v.wbr;
    #1;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, ".stall"}, 32'(stall), 32'(v.st));
    chk({tag, ".fire"},  32'(issue_fire), 32'(v.fi));
    chk({tag, ".busy"},  32'(busy_vec), 32'(v.bv));
    chk({tag, ".err"},   32'(err), 32'(v.er));
  endtask

  function automatic bit mbusy(int r, bit wbv, int wbr);
    bit b;
    if (r == 0) return 1'b0;
    b = (cnt_m[r] != 0);
`ifdef SB_WB_BYPASS_EN
    if (cnt_m[r] == 1 && wbv && wbr == r) b = 1'b0;
`endif
    return b;
  endfunction

  // Fill v.st/fi/bv/er from the model for the current cycle.
  function automatic vec_t model_eval(vec_t v);
    vec_t e = v;
    bit full;
    full = v.irw && v.iwr != 0 && cnt_m[v.iwr] == 3 && !(v.wb && v.wbr == v.iwr);
    e.st = v.iv && ((v.u1 && mbusy(int'(v.rr1), v.wb, int'(v.wbr))) ||
                    (v.u2 && mbusy(int'(v.rr2), v.wb, int'(v.wbr))) || full);
    e.fi = v.iv && !e.st;
    e.bv = '0;
    for (int r = 1; r < 8; r++) e.bv[r] = (cnt_m[r] != 0);
    e.er = err_m;
    return e;
  endfunction

  task automatic model_commit(input vec_t e);
    if (e.rst) begin
      for (int r = 0; r < 8; r++) cnt_m[r] = 0;
      err_m = 1'b0;
    end else begin
      bit retire;
      retire = e.wb && e.wbr != 0 && cnt_m[e.wbr] > 0;
      if (e.wb && e.wbr != 0 && cnt_m[e.wbr] == 0) err_m = 1'b1;
      if (e.fi && e.irw && e.iwr != 0) cnt_m[e.iwr] = cnt_m[e.iwr] + 1;
      if (retire) cnt_m[e.wbr] = cnt_m[e.wbr] - 1;
    end
  endtask

  vec_t tbl [16];
  vec_t v, e;

  initial begin
    rst = 1'b1; issue_valid = 0; issue_regwrite = 0; issue_writereg = 0;
    readreg1 = 0; readreg2 = 0; uses_rs1 = 0; uses_rs2 = 0;
    wb_regwrite = 0; wb_writereg = 0;

    //            rst iv irw iwr rr1 rr2 u1 u2 wb wbr  st fi  bv   er
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 'h00, 0);
    tbl[1]  = mk(0, 1, 1, 3, 0, 0, 0, 0, 0, 0,  0, 1, 'h00, 0);
    tbl[2]  = mk(0, 1, 1, 1, 3, 0, 1, 0, 0, 0,  1, 0, 'h08, 0);
    tbl[3]  = mk(0, 0, 0, 0, 3, 0, 1, 0, 0, 0,  0, 0, 'h08, 0);
    tbl[4]  = mk(0, 1, 1, 5, 0, 0, 0, 0, 0, 0,  0, 1, 'h08, 0);
    tbl[5]  = mk(0, 1, 1, 5, 0, 0, 0, 0, 0, 0,  0, 1, 'h28, 0);
    tbl[6]  = mk(0, 1, 1, 5, 0, 0, 0, 0, 0, 0,  0, 1, 'h28, 0);
    tbl[7]  = mk(0, 1, 1, 5, 0, 0, 0, 0, 0, 0,  1, 0, 'h28, 0);
    tbl[8]  = mk(0, 1, 1, 5, 0, 0, 0, 0, 1, 5,  0, 1, 'h28, 0);
    tbl[9]  = mk(0, 1, 1, 0, 0, 0, 1, 1, 1, 0,  0, 1, 'h28, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 6,  0, 0, 'h28, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 'h28, 1);
    tbl[12] = mk(0, 1, 1, 2, 0, 0, 0, 0, 0, 0,  0, 1, 'h28, 1);
    tbl[13] = mk(0, 1, 1, 4, 0, 0, 0, 0, 0, 0,  0, 1, 'h2C, 1);
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 'h3C, 1);
    tbl[15] = mk(0, 1, 0, 0, 2, 0, 1, 0, 0, 0,  0, 1, 'h00, 0);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i]);
      check_vec($sformatf("tbl%0d", i), tbl[i]);
    end

    // Writeback of r3 while a reader of r3 waits.
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h00, 0));
    drive(mk(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 'h00, 0));
    check_vec("byp_issue", mk(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 'h00, 0));
    v = mk(0, 1, 0, 0, 3, 0, 1, 0, 1, 3, 0, 0, 0, 0);
    drive(v);
`ifdef SB_WB_BYPASS_EN
    check_vec("byp_wb", mk(0, 1, 0, 0, 3, 0, 1, 0, 1, 3, 0, 1, 'h08, 0));
`else
    check_vec("byp_wb", mk(0, 1, 0, 0, 3, 0, 1, 0, 1, 3, 1, 0, 'h08, 0));
`endif
    drive(mk(0, 1, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    check_vec("byp_next", mk(0, 1, 0, 0, 3, 0, 1, 0, 0, 0, 0, 1, 'h00, 0));

    // Randomized run against the reference model.
    for (int r = 0; r < 8; r++) cnt_m[r] = 0;
    err_m = 1'b0;
    v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(v);
    e = model_eval(v);
    model_commit(e);
    for (int i = 0; i < 3000; i++) begin
      v.rst = ($urandom_range(0, 99) == 0);
      v.iv  = ($urandom_range(0, 3) != 0);
      v.irw = ($urandom_range(0, 3) != 0);
      v.iwr = 3'($urandom);
      v.rr1 = 3'($urandom);
      v.rr2 = 3'($urandom);
      v.u1  = 1'($urandom);
      v.u2  = 1'($urandom);
      v.wb  = ($urandom_range(0, 2) != 0);
      v.wbr = 3'($urandom);
      drive(v);
      e = model_eval(v);
      check_vec($sformatf("rnd%0d", i), e);
      model_commit(e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Issue-side read-hazard guard for the 16-bit pipelined MIPS datapath. It sits in the decode stage in front of the register file's two combinational read ports. It tracks every in-flight write to each of the 8 architectural registers, using the same 3-bit register indices as the register file. It stalls any instruction whose source operands are still awaiting writeback. Writeback retires entries using the same `regwrite`/`writereg` pair that drives the register file write port.

## Interface
Clock and reset are listed first. One clock; reset is synchronous and active-high.

Parameters:
- NREGS, 8, number of architectural registers; r0 is hardwired zero.
- AW, 3, register index width.
- CW, 2, width of each per-register pending counter; max outstanding writes per register = 2^CW-1.

Ports:
- clk  in  1  pipeline clock; all state updates on the posedge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  decode holds an instruction requesting issue.
- issue_regwrite  in  1  the issuing instruction writes a register.
- issue_writereg  in  AW  destination register of the issuing instruction.
- readreg1, readreg2  in  AW  source register indices.
- uses_rs1, uses_rs2  in  1  the source is actually read.
- wb_regwrite  in  1  writeback is committing a register write this cycle.
- wb_writereg  in  AW  register being committed.
- stall  out  1  combinational; hold decode and do not issue.
- issue_fire  out  1  combinational; issue_valid & ~stall.
- busy_vec  out  NREGS  registered; bit r = counter r nonzero; bit 0 always 0.
- err  out  1  registered, sticky; writeback retired a register with no pending write.

## Operation
- Each register r in 1..NREGS-1 has an unsigned CW-bit counter, cnt[r].
- Register r0 has no counter. Issue or writeback targeting r0 is ignored and never sets err.
- Increment condition: inc[r] = issue_fire & issue_regwrite & issue_writereg==r.
- Decrement condition: dec[r] = wb_regwrite & wb_writereg==r & cnt[r]!=0.
- Counter update:
  - inc & dec: no change.
  - inc only: +1.
  - dec only: -1.
- Counters never wrap. Underflow is prevented by dec[r]. Overflow is prevented by the full-stall rule below.
- busy(r) = cnt[r]!=0. With the bypass feature, the exception defined under Configuration applies.
- stall is asserted when issue_valid and any of the following holds:
  - uses_rs1 & busy(readreg1);
  - uses_rs2 & busy(readreg2);
  - issue_regwrite & issue_writereg!=0 & cnt[issue_writereg]==max & ~(wb_regwrite & wb_writereg==issue_writereg).
- stall is 0 whenever issue_valid is 0.
- Multiple outstanding writes to the same register (WAW) are allowed up to max. Writeback is in order, so retires decrement in issue order.
- err is set when wb_regwrite & wb_writereg!=0 & cnt[wb_writereg]==0. err stays set until rst.

## Timing
- Reset: all counters 0, busy_vec 0, err 0. stall and issue_fire follow the inputs, with all counters reading 0 in the same cycle.
- An rst assertion mid-operation clears every counter at that edge, discarding pending writes. Any inc or dec in that cycle is ignored.
- stall is combinational from the current counters and the current-cycle inputs. No extra latency.
- A counter changes at the posedge following issue_fire or a wb commit. busy_vec reflects the change one cycle later.
- A source that matches an instruction issuing in the same cycle is not a hazard for that instruction itself.
- Issue and retire of the same register in the same cycle leave the count unchanged. This holds even at max.

## Configuration
- Macro: SB_WB_BYPASS_EN.
- Defined:
  - The register file writes on the negedge, so a source register whose final pending write commits this cycle is readable.
  - busy(r) = cnt[r]!=0 & ~(cnt[r]==1 & wb_regwrite & wb_writereg==r).
- Undefined:
  - busy(r) = cnt[r]!=0.
  - A dependent instruction stalls through the writeback cycle and issues one cycle later.
- busy_vec is the registered count state in both builds; it is unaffected by the macro.

## Structure
- Shared package mips_pkg holds:
  - REG_AW = 3 and NREGS = 8;
  - type reg_idx_t;
  - constant REG_ZERO.
- Sub-module sb_counter: one per-register saturating up/down counter with inc, dec and clear inputs, and busy and count outputs. Instantiated NREGS-1 times. The top level holds the index decode, stall logic and err flag.

## Test plan
- Reset, then issue `add r3` -> cnt[3]=1 and busy_vec=8'b0000_1000 on the next cycle. A following instruction reading r3 sees stall=1 and issue_fire=0.
- wb_regwrite with wb_writereg=3 while a reader of r3 waits:
  - bypass build: stall drops in the same cycle;
  - non-bypass build: stall drops the next cycle.
  - In both builds busy_vec returns to 0.
- Three issues to r5 with no writeback -> cnt=3. A fourth issue to r5 stalls. Adding a same-cycle wb to r5 lets it fire, and cnt stays 3.
- Issue writing r0, and sources r0 -> never stall and never busy. wb to r0 leaves err=0.
- wb to r6 while cnt[6]=0 -> err=1 next cycle and stays 1; cnt[6] stays 0. rst clears err and all counters.
- Pending r2 and r4, then rst asserted for one cycle -> busy_vec=0, and a reader of r2 issues immediately.
